// File: rtl/mips_pkg.sv
// Types and constants shared by the MIPS pipeline stages.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        DROP,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: enable-gated load, bubble-load clears valid only.
module if_id_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pcplus4_in,
    output logic [31:0] instr,
    output logic [31:0] pcplus4,
    output logic        valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr   <= 32'h0;
            pcplus4 <= 32'h0;
            valid   <= 1'b0;
        end else if (en) begin
            if (bubble) begin
                // Payload is kept on a bubble; decode ignores it while valid is low.
                valid <= 1'b0;
            end else begin
                instr   <= instr_in;
                pcplus4 <= pcplus4_in;
                valid   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, instruction-memory handshake, stall hold buffer,
// wrong-path drop state and the IF/ID register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRdata,
    input  logic        ImemReady,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pc4_q, buf_pc4_d;
    logic [31:0]  pend_pc_q, pend_pc_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        ifid_bubble;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;

    assign redirect = (JumpD | PCSrcD) & ValidD & ~StallD;
    assign target   = JumpD ? PCJumpD : PCBranchD;
    assign pc_plus4 = pc_q + 32'd4;

    assign PCF      = pc_q;
    assign ImemAddr = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        pend_pc_d   = pend_pc_q;
        ifid_bubble = 1'b1;
        ifid_instr  = ImemRdata;
        ifid_pc4    = pc_plus4;
        ImemReq     = 1'b1;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (ImemReady) begin
                        pc_d = target;
                    end else begin
                        // The in-flight transfer must finish before the target is issued.
                        pend_pc_d = target;
                        state_d   = DROP;
                    end
                end else if (ImemReady) begin
                    pc_d = pc_plus4;
                    if (StallD) begin
                        buf_instr_d = ImemRdata;
                        buf_pc4_d   = pc_plus4;
                        state_d     = HOLD;
                    end else begin
                        ifid_bubble = 1'b0;
                    end
                end
            end
            DROP: begin
                if (ImemReady) begin
                    pc_d    = pend_pc_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                ImemReq = 1'b0;
                if (!StallD) begin
                    state_d = FETCH;
                    if (redirect) begin
                        pc_d = target;
                    end else begin
                        ifid_bubble = 1'b0;
                        ifid_instr  = buf_instr_q;
                        ifid_pc4    = buf_pc4_q;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            buf_instr_q <= 32'h0;
            buf_pc4_q   <= 32'h0;
            pend_pc_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            pend_pc_q   <= pend_pc_d;
        end
    end

    // Every non-stalled cycle writes either a word or a bubble into decode.
    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .en         (~StallD),
        .bubble     (ifid_bubble),
        .instr_in   (ifid_instr),
        .pcplus4_in (ifid_pc4),
        .instr      (InstrD),
        .pcplus4    (PCPlus4D),
        .valid      (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed bench for fetch_stage against a transaction-level model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic [31:0] PCJumpD;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] ImemRdata;
    logic        ImemReady;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .StallD    (StallD),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .JumpD     (JumpD),
        .PCJumpD   (PCJumpD),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemRdata (ImemRdata),
        .ImemReady (ImemReady),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign ImemRdata = memf(ImemAddr);

    // Observed vector: {PCF, ImemReq, ValidD, InstrD, PCPlus4D, ImemAddr}
    logic [129:0] obs;
    assign obs = {PCF, ImemReq, ValidD, InstrD, PCPlus4D, ImemAddr};

    localparam logic [129:0] RESET_VEC = {32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    // Model: fetch PC, decode slot, words waiting behind a stall, pending wrong-path target.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    entry_t      held_q[$];
    logic [31:0] drop_q[$];

    int checks = 0;
    int fails  = 0;

    function automatic logic [129:0] exp_vec();
        return {m_pc, (held_q.size() == 0), m_valid, m_instr, m_pc4, m_pc};
    endfunction

    task automatic m_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        held_q.delete();
        drop_q.delete();
    endtask

    task automatic m_step(input bit stall, input bit ready, input bit jump, input bit pcsrc,
                          input logic [31:0] bt, input logic [31:0] jt);
        bit          redir;
        logic [31:0] tgt;
        entry_t      e;
        redir = (jump || pcsrc) && m_valid && !stall;
        tgt   = jump ? jt : bt;
        if (held_q.size() != 0) begin
            if (!stall) begin
                if (redir) begin
                    held_q.delete();
                    m_pc    = tgt;
                    m_valid = 1'b0;
                end else begin
                    e       = held_q.pop_front();
                    m_instr = e.instr;
                    m_pc4   = e.pc4;
                    m_valid = 1'b1;
                end
            end
        end else if (drop_q.size() != 0) begin
            if (!stall) m_valid = 1'b0;
            if (ready) m_pc = drop_q.pop_front();
        end else if (redir) begin
            m_valid = 1'b0;
            if (ready) m_pc = tgt;
            else drop_q.push_back(tgt);
        end else if (ready) begin
            if (stall) begin
                e.instr = memf(m_pc);
                e.pc4   = m_pc + 32'd4;
                held_q.push_back(e);
            end else begin
                m_instr = memf(m_pc);
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit stall, input bit ready, input bit jump, input bit pcsrc,
                        input logic [31:0] bt, input logic [31:0] jt);
        StallD    = stall;
        ImemReady = ready;
        JumpD     = jump;
        PCSrcD    = pcsrc;
        PCBranchD = bt;
        PCJumpD   = jt;
        m_step(stall, ready, jump, pcsrc, bt, jt);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        StallD = 1'b0; ImemReady = 1'b0; JumpD = 1'b0; PCSrcD = 1'b0;
        m_reset();
        #2;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (obs !== RESET_VEC) begin
            fails++;
            $display("FAIL reset: got %h want %h", obs, RESET_VEC);
        end
        release_reset();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL sequential[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_wait();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            checks++;
            if (obs !== exp_vec() || ImemAddr !== 32'h10 || ValidD !== 1'b0) begin
                fails++;
                $display("FAIL wait[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (InstrD !== memf(32'h10) || obs !== exp_vec()) begin
            fails++;
            $display("FAIL wait_done: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_redirect();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
        checks++;
        if (PCF !== 32'h100 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL branch: got %h want %h", obs, exp_vec());
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h200);
        checks++;
        if (PCF !== 32'h200 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL jump_priority: got %h want %h", obs, exp_vec());
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (InstrD !== memf(32'h200) || obs !== exp_vec()) begin
            fails++;
            $display("FAIL jump_target: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_drop();
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h400);
        for (int i = 0; i < 3; i++) begin
            step(i == 1, i == 2, 1'b0, 1'b0, 32'h0, 32'h0);
            checks++;
            if (obs !== exp_vec() || ValidD !== 1'b0) begin
                fails++;
                $display("FAIL drop[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (InstrD !== memf(32'h400) || obs !== exp_vec()) begin
            fails++;
            $display("FAIL drop_target: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_hold();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h80);
            checks++;
            if (obs !== exp_vec() || ImemReq !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp_vec()) begin
            fails++;
            $display("FAIL hold_release: got %h want %h", obs, exp_vec());
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h800);
        checks++;
        if (PCF !== 32'h800 || ValidD !== 1'b0 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL hold_redirect: got %h want %h", obs, exp_vec());
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (InstrD !== memf(32'h800) || obs !== exp_vec()) begin
            fails++;
            $display("FAIL hold_target: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (PCF !== 32'h0 || PCPlus4D !== 32'h0 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL wrap: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        // Enter DROP, then HOLD, resetting asynchronously in each.
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            if (k == 0) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 32'h0);
            else        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            apply_reset();
            checks++;
            if (obs !== RESET_VEC) begin
                fails++;
                $display("FAIL reset_mid[%0d]: got %h want %h", k, obs, RESET_VEC);
            end
            release_reset();
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            checks++;
            if (PCF !== 32'h8 || obs !== exp_vec()) begin
                fails++;
                $display("FAIL reset_resume[%0d]: got %h want %h", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit          s, r, j, p;
        logic [31:0] bt, jt;
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 9) < 6);
            j  = ($urandom_range(0, 9) == 0);
            p  = ($urandom_range(0, 6) == 0);
            bt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            jt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 1023), 2'b00};
            bt = bt[31:0];
            step(s, r, j, p, bt, jt);
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        PCBranchD = 32'h0;
        PCJumpD   = 32'h0;
        test_reset();
        test_sequential();
        test_wait();
        test_redirect();
        test_drop();
        test_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
